// File: rtl/addac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addac_pkg
//  Description : Shared types and helpers for the ADDAC bit-serial adder.
//                Provides the FSM state type, the default operand width and
//                the bit-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package addac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } addac_state_t;

  localparam int ADDAC_DEFAULT_WIDTH = 8;

  // Width of a counter indexing bits 0..width-1 (never below 1 bit).
  function automatic int addac_cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addac_serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : addac_serial_adder_if
//  Description : Request/response bundle of the ADDAC bit-serial adder.
//                master : control side (drives start/op_sub/a_in/b_in)
//                slave  : adder side (drives busy, serial stream, result, flags)
//  Ports       : start, op_sub, a_in[WIDTH], b_in[WIDTH]      (master -> slave)
//                busy, sum_bit, acc_en, done, result[WIDTH],
//                carry_out, overflow                          (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface addac_serial_adder_if
  import addac_pkg::*;
#(
  parameter int WIDTH = ADDAC_DEFAULT_WIDTH
);

  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             sum_bit;
  logic             acc_en;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, op_sub, a_in, b_in,
    input  busy, sum_bit, acc_en, done, result, carry_out, overflow
  );

  modport slave (
    input  start, op_sub, a_in, b_in,
    output busy, sum_bit, acc_en, done, result, carry_out, overflow
  );

endinterface
`default_nettype wire

// File: rtl/addac_bit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : addac_bit_adder
//  Description : One-bit full adder with its carry flip-flop. The carry is
//                preset through load/load_val at the start of an operation
//                (1 for subtract, giving the +1 of two's complement) and
//                advances with en while bits are being processed.
//  Ports       : clk, rst (async, active-high)
//                load, load_val : preset carry
//                en             : commit carry-out into the carry flop
//                a, b           : operand bits
//                sum            : a ^ b ^ carry
//                carry          : current carry (carry into this bit)
//                cout           : carry out of this bit
//  Revision    : 1.0 - initial release
// ============================================================================
module addac_bit_adder (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_val,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry,
  output logic cout
);

  logic carry_q;

  assign carry = carry_q;
  assign sum   = a ^ b ^ carry_q;
  assign cout  = (a & b) | (a & carry_q) | (b & carry_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (load) begin
      carry_q <= load_val;
    end else if (en) begin
      carry_q <= cout;
    end
  end

endmodule
`default_nettype wire

// File: rtl/addac_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : addac_serial_adder
//  Description : Bit-serial add/subtract stage feeding the ADDAC accumulator.
//                Emits one sum bit per clock (LSB first) with acc_en, then
//                pulses done with the assembled result, carry_out and signed
//                overflow. Operation latency is WIDTH+1 clocks.
//  Ports       : clk, rst (async, active-high), bus (addac_serial_adder_if.slave)
//  Options     : ADDAC_BACK2BACK_EN - when defined, start seen in DONE launches
//                the next operation directly (one op per WIDTH+1 clocks);
//                otherwise DONE always returns to IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module addac_serial_adder
  import addac_pkg::*;
#(
  parameter int WIDTH = ADDAC_DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  addac_serial_adder_if.slave  bus
);

  localparam int            CW   = addac_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  addac_state_t     state;
  addac_state_t     state_nxt;
  logic             accept;
  logic             shifting;
  logic             last_bit;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] result_r;
  logic [CW-1:0]    cnt;
  logic             carry_out_r;
  logic             overflow_r;

  logic             fa_sum;
  logic             fa_carry;
  logic             fa_cout;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
`ifdef ADDAC_BACK2BACK_EN
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign shifting = (state == SHIFT);
  assign last_bit = shifting && (cnt == LAST);

  // --------------------------------------------------------------------------
  // Serial full adder with carry flop
  // --------------------------------------------------------------------------
  addac_bit_adder u_bit_adder (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (bus.op_sub),
    .en       (shifting),
    .a        (a_sr[0]),
    .b        (b_sr[0]),
    .sum      (fa_sum),
    .carry    (fa_carry),
    .cout     (fa_cout)
  );

  // --------------------------------------------------------------------------
  // Operand shift registers, result assembly, counter and flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr        <= '0;
      b_sr        <= '0;
      result_r    <= '0;
      cnt         <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (accept) begin
      // Subtract is A + ~B + 1; the +1 comes from the preset carry.
      a_sr        <= bus.a_in;
      b_sr        <= bus.op_sub ? ~bus.b_in : bus.b_in;
      result_r    <= '0;
      cnt         <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (shifting) begin
      a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
      result_r <= {fa_sum, result_r[WIDTH-1:1]};
      cnt      <= last_bit ? '0 : cnt + CW'(1);
      if (last_bit) begin
        // On the MSB, fa_carry is the carry into it and fa_cout the carry out.
        carry_out_r <= fa_cout;
        overflow_r  <= fa_carry ^ fa_cout;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy      = (state != IDLE);
  assign bus.acc_en    = shifting;
  assign bus.sum_bit   = shifting & fa_sum;
  assign bus.done      = (state == DONE);
  assign bus.result    = result_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;

endmodule
`default_nettype wire

// File: tb/tb_addac_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addac_serial_adder
//  Description : Scoreboard bench for addac_serial_adder. Expected results
//                come from an arithmetic reference model; a monitor compares
//                them against every done pulse together with the serial
//                stream, acc_en length, latency and burst spacing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addac_serial_adder;
  import addac_pkg::*;

  localparam int WIDTH = 8;
`ifdef ADDAC_BACK2BACK_EN
  localparam int PERIOD = WIDTH + 1;
`else
  localparam int PERIOD = WIDTH + 2;
`endif

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ov;
    int               e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addac_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  addac_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   pushed    = 0;
  int   done_seen = 0;
  int   last_done = -1;
  bit   burst     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: plain modular and signed integer arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub, input int e0);
    exp_t   e;
    longint m  = longint'(1) << WIDTH;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint u;
    longint s;
    if (sub) begin
      u    = ua - ub;
      s    = sa - sb;
      e.co = (ua >= ub);
    end else begin
      u    = ua + ub;
      s    = sa + sb;
      e.co = (u >= m);
    end
    e.res = WIDTH'(((u % m) + m) % m);
    e.ov  = (s > m / 2 - 1) || (s < -(m / 2));
    e.e0  = e0;
    return e;
  endfunction

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] col;
  int               en_cnt;
  exp_t             me;

  always @(negedge clk) begin
    if (rst) begin
      col    = '0;
      en_cnt = 0;
    end else begin
      if (bus.acc_en) begin
        col = {bus.sum_bit, col[WIDTH-1:1]};
        en_cnt++;
      end else begin
        check("sum_bit_outside_shift", bus.sum_bit, 0);
      end
      if (bus.done) begin
        done_seen++;
        check("busy_in_done", bus.busy, 1);
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          me = q.pop_front();
          check("result", bus.result, me.res);
          check("carry_out", bus.carry_out, me.co);
          check("overflow", bus.overflow, me.ov);
          check("serial_bits", col, me.res);
          check("acc_en_cycles", en_cnt, WIDTH);
          check("done_latency", cyc - me.e0, WIDTH);
        end
        if (burst && last_done >= 0) begin
          check("done_spacing", cyc - last_done, PERIOD);
        end
        last_done = cyc;
        col       = '0;
        en_cnt    = 0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    @(negedge clk);
    bus.a_in   = a;
    bus.b_in   = b;
    bus.op_sub = sub;
    bus.start  = 1'b1;
    @(negedge clk);
    q.push_back(model(a, b, sub, cyc));
    pushed++;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy && q.size() == 0) return;
    end
    check("idle_timeout", 1, 0);
  endtask

  initial begin
    int   n;
    logic prev;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_sum_bit", bus.sum_bit, 0);
    check("rst_acc_en", bus.acc_en, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_carry_out", bus.carry_out, 0);
    check("rst_overflow", bus.overflow, 0);
    rst = 1'b0;

    // Directed corner cases
    do_op(8'h25, 8'h1A, 1'b0); wait_idle();
    do_op(8'hFF, 8'h01, 1'b0); wait_idle();
    do_op(8'h7F, 8'h01, 1'b0); wait_idle();
    do_op(8'h10, 8'h20, 1'b1); wait_idle();
    do_op(8'h80, 8'h01, 1'b1); wait_idle();
    do_op(8'h00, 8'h00, 1'b1); wait_idle();

    // start pulsed with new operands in SHIFT cycle 3 must be ignored
    do_op(8'h25, 8'h1A, 1'b0);
    repeat (3) @(negedge clk);
    bus.a_in  = 8'hFF;
    bus.b_in  = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);

    // Reset during SHIFT cycle 4 aborts asynchronously
    do_op(8'h25, 8'h1A, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_acc_en", bus.acc_en, 0);
    check("abort_result", bus.result, 0);
    check("abort_done", bus.done, 0);
    q.delete();
    pushed--;
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h7F, 8'h01, 1'b0); wait_idle();

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      wait_idle();
    end

    // start held high continuously: spacing depends on back-to-back option
    burst      = 1'b1;
    last_done  = -1;
    n          = 0;
    prev       = bus.acc_en;
    bus.a_in   = WIDTH'($urandom);
    bus.b_in   = WIDTH'($urandom);
    bus.op_sub = 1'($urandom);
    bus.start  = 1'b1;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (bus.acc_en && !prev) begin
        q.push_back(model(bus.a_in, bus.b_in, bus.op_sub, cyc));
        pushed++;
        n++;
        bus.a_in   = WIDTH'($urandom);
        bus.b_in   = WIDTH'($urandom);
        bus.op_sub = 1'($urandom);
        if (n == 4) bus.start = 1'b0;
      end
      prev = bus.acc_en;
    end
    bus.start = 1'b0;
    if (n < 4) check("burst_accept_timeout", n, 4);
    wait_idle();
    burst = 1'b0;

    repeat (3) @(negedge clk);
    check("done_count", done_seen, pushed);
    check("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
